// File: rtl/foc_angle_sequencer.sv
// foc_angle_sequencer: per-PWM-event theta advance, sin/cos handshake and amplitude scaling to alpha/beta.
// Define FOC_ANGLE_SEQUENCER_RAMP_EN to slew the effective step by RAMP_RATE per accepted event.
module foc_angle_sequencer #(
  parameter int PHASE_PI     = 102943,
  parameter int WAIT_TIMEOUT = 63,
  parameter int RAMP_RATE    = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic        pwm_event,
  input  logic [17:0] step,
  input  logic [15:0] amp,
  output logic [17:0] theta_tdata,
  output logic        theta_tvalid,
  input  logic [33:0] sin_cos_tdata,
  input  logic        sin_cos_tvalid,
  output logic [31:0] alpha_beta_tdata,
  output logic        alpha_beta_tvalid,
  output logic        busy,
  output logic        overrun,
  output logic        fault
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SCALE, OUT} state_e;
  localparam int CW = $clog2(WAIT_TIMEOUT + 1);
  localparam logic signed [18:0] PI  = 19'(PHASE_PI);
  localparam logic signed [18:0] PI2 = 19'(2 * PHASE_PI);
  if (RAMP_RATE < 0 || WAIT_TIMEOUT < 1 || PHASE_PI < 1) begin : g_bad_params
    $error("foc_angle_sequencer: invalid parameters");
  end
  state_e state_q, state_d;
  logic [17:0] theta_q, theta_d, step_eff;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [33:0] sc_q, sc_d;
  logic [31:0] ab_q, ab_d;
  logic fault_q, fault_d, overrun_q, overrun_d;
  logic accept, timeout;
  logic signed [18:0] sum, wrapped;
  logic signed [33:0] prod_a, prod_b;
  function automatic logic [15:0] sat16(input logic signed [33:0] p);
    logic signed [18:0] s;
    s = p[33:15];
    return s > 19'sd32767 ? 16'h7fff : s < -19'sd32768 ? 16'h8000 : s[15:0];
  endfunction
  assign accept  = state_q == IDLE && pwm_event && enable && !fault_q;
  assign timeout = cnt_q == CW'(WAIT_TIMEOUT - 1);
  assign sum     = {theta_q[17], theta_q} + {step_eff[17], step_eff};
  assign wrapped = sum > PI ? sum - PI2 : sum < -PI ? sum + PI2 : sum;
  // amp is unsigned, so widen it with a zero sign bit before the signed multiply
  assign prod_a  = $signed(sc_q[16:0]) * $signed({1'b0, amp});
  assign prod_b  = $signed(sc_q[33:17]) * $signed({1'b0, amp});
`ifdef FOC_ANGLE_SEQUENCER_RAMP_EN
  localparam logic signed [18:0] RR = 19'(RAMP_RATE);
  logic [17:0] step_eff_q;
  logic signed [18:0] diff;
  assign diff     = {step[17], step} - {step_eff_q[17], step_eff_q};
  assign step_eff = diff > RR ? step_eff_q + RR[17:0] : diff < -RR ? step_eff_q - RR[17:0] : step;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) step_eff_q <= '0;
    else if (accept) step_eff_q <= step_eff;
`else
  assign step_eff = step;
`endif
  always_comb begin
    state_d   = state_q;
    theta_d   = accept ? wrapped[17:0] : theta_q;
    cnt_d     = '0;
    sc_d      = sc_q;
    ab_d      = ab_q;
    fault_d   = fault_q;
    overrun_d = pwm_event && enable && state_q != IDLE;
    if (!enable) begin
      state_d = IDLE;
      fault_d = 1'b0;
    end else begin
      case (state_q)
        IDLE:  state_d = accept ? ISSUE : IDLE;
        ISSUE: state_d = WAIT;
        WAIT: begin
          cnt_d   = cnt_q + 1'b1;
          sc_d    = sin_cos_tvalid ? sin_cos_tdata : sc_q;
          state_d = sin_cos_tvalid ? SCALE : timeout ? IDLE : WAIT;
          fault_d = fault_q | (!sin_cos_tvalid && timeout);
        end
        SCALE: begin
          ab_d    = {sat16(prod_a), sat16(prod_b)};
          state_d = OUT;
        end
        OUT:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q   <= IDLE;
      theta_q   <= '0;
      cnt_q     <= '0;
      sc_q      <= '0;
      ab_q      <= '0;
      fault_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      theta_q   <= theta_d;
      cnt_q     <= cnt_d;
      sc_q      <= sc_d;
      ab_q      <= ab_d;
      fault_q   <= fault_d;
      overrun_q <= overrun_d;
    end
  assign theta_tdata       = theta_q;
  assign theta_tvalid      = state_q == ISSUE && enable;
  assign alpha_beta_tdata  = ab_q;
  assign alpha_beta_tvalid = state_q == OUT && enable;
  assign busy              = state_q != IDLE;
  assign overrun           = overrun_q;
  assign fault             = fault_q;
endmodule
